// File: rtl/mem_stage_unit.sv
// mem_stage_unit: RISC-V MEM stage doing 64-bit loads/stores over req/ack, with stall, branch resolve and the MEM/WB register
// Ports: clk, reset_n (async, active-low); EX/MEM controls (mem_to_reg, reg_write_en, mem_read, mem_write, branch, z_flag),
//        alu_out (address or ALU result), data (store data), rd, pc_next; data-memory bus dmem_req/we/addr/wdata/rdata/ack;
//        stall, pc_src, pc_target; misaligned_err/bus_err pulses; MEM/WB outputs *_out, mem_data_out.
module mem_stage_unit #(
  parameter int TIMEOUT = 16
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        mem_to_reg,
  input  logic        reg_write_en,
  input  logic        mem_read,
  input  logic        mem_write,
  input  logic        branch,
  input  logic        z_flag,
  input  logic [63:0] alu_out,
  input  logic [63:0] data,
  input  logic [4:0]  rd,
  input  logic [63:0] pc_next,
  output logic        dmem_req,
  output logic        dmem_we,
  output logic [63:0] dmem_addr,
  output logic [63:0] dmem_wdata,
  input  logic [63:0] dmem_rdata,
  input  logic        dmem_ack,
  output logic        stall,
  output logic        pc_src,
  output logic [63:0] pc_target,
  output logic        misaligned_err,
  output logic        bus_err,
  output logic        mem_to_reg_out,
  output logic        reg_write_en_out,
  output logic [63:0] alu_out_out,
  output logic [63:0] mem_data_out,
  output logic [4:0]  rd_out
);
  typedef enum logic {IDLE, REQ} state_t;
  // Counter value seen on the TIMEOUT-th REQ cycle without an ack
  localparam logic [7:0] LAST = 8'(TIMEOUT - 1);
  state_t state, state_nx;
  logic [7:0] cnt;
  logic access, aligned, start, misalign, ack_done, abort, capture;
  assign access = mem_read | mem_write;
  assign aligned = alu_out[2:0] == 3'b000;
  assign pc_src = branch & z_flag;
  assign pc_target = pc_next;
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else state <= state_nx;
  end
  always_comb begin
    state_nx = state;
    start = 1'b0;
    misalign = 1'b0;
    ack_done = 1'b0;
    abort = 1'b0;
    if (state == IDLE) begin
      start = access & aligned;
      misalign = access & !aligned;
      state_nx = start ? REQ : IDLE;
    end else begin
      ack_done = dmem_ack;
      abort = !dmem_ack && cnt >= LAST;
      state_nx = (dmem_ack | abort) ? IDLE : REQ;
    end
  end
  // Gated with reset_n so the pipeline is released while reset is held
  assign stall = reset_n & (start | (state == REQ & !ack_done & !abort));
  // Only a non-memory instruction in IDLE or a completed access reaches WB; everything else is a bubble
  assign capture = (state == IDLE & !access) | ack_done;
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt <= '0;
      dmem_req <= 1'b0;
      dmem_we <= 1'b0;
      dmem_addr <= '0;
      dmem_wdata <= '0;
      misaligned_err <= 1'b0;
      bus_err <= 1'b0;
      mem_to_reg_out <= 1'b0;
      reg_write_en_out <= 1'b0;
      alu_out_out <= '0;
      mem_data_out <= '0;
      rd_out <= '0;
    end else begin
      cnt <= start ? '0 : (state == REQ && cnt != 8'hff) ? cnt + 8'd1 : cnt;
      dmem_req <= state_nx == REQ;
      if (start) begin
        dmem_we <= mem_write;
        dmem_addr <= alu_out;
        dmem_wdata <= data;
      end
      misaligned_err <= misalign;
      bus_err <= abort;
      mem_to_reg_out <= capture & mem_to_reg;
      reg_write_en_out <= capture & reg_write_en;
      alu_out_out <= capture ? alu_out : '0;
      mem_data_out <= (ack_done && !dmem_we) ? dmem_rdata : '0;
      rd_out <= capture ? rd : '0;
    end
  end
endmodule

// File: tb/tb_mem_stage_unit.sv
// tb_mem_stage_unit: randomized scoreboard bench for mem_stage_unit with a memory responder model
module tb_mem_stage_unit;
  localparam int TO = 4;
  logic clk = 1'b0;
  logic reset_n = 1'b0;
  logic mem_to_reg, reg_write_en, mem_read, mem_write, branch, z_flag;
  logic [63:0] alu_out, data, pc_next;
  logic [4:0] rd, rd_out;
  logic dmem_req, dmem_we, stall, pc_src, misaligned_err, bus_err, mem_to_reg_out, reg_write_en_out;
  logic [63:0] dmem_addr, dmem_wdata, pc_target, alu_out_out, mem_data_out;
  logic dmem_ack = 1'b0;
  logic [63:0] dmem_rdata = '0;
  typedef struct packed {
    logic m2r, rwe, mis, berr, req, chk_md;
    logic [63:0] alu, md;
    logic [4:0] rd;
  } exp_t;
  exp_t q[$];
  int errors = 0;
  int checks = 0;
  logic [63:0] mem [logic [63:0]];
  int ack_delay = 0;
  int rcnt = 0;
  logic [63:0] cur_addr = '0;
  logic [63:0] cur_wdata = '0;
  logic cur_we = 1'b0;

  mem_stage_unit #(.TIMEOUT(TO)) dut (
    .clk(clk), .reset_n(reset_n), .mem_to_reg(mem_to_reg), .reg_write_en(reg_write_en),
    .mem_read(mem_read), .mem_write(mem_write), .branch(branch), .z_flag(z_flag),
    .alu_out(alu_out), .data(data), .rd(rd), .pc_next(pc_next),
    .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata),
    .dmem_rdata(dmem_rdata), .dmem_ack(dmem_ack), .stall(stall), .pc_src(pc_src), .pc_target(pc_target),
    .misaligned_err(misaligned_err), .bus_err(bus_err), .mem_to_reg_out(mem_to_reg_out),
    .reg_write_en_out(reg_write_en_out), .alu_out_out(alu_out_out), .mem_data_out(mem_data_out), .rd_out(rd_out)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input bit ok, input string detail);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL %s: %s", name, detail);
    end
  endtask

  function automatic logic [63:0] rmem(input logic [63:0] a);
    return mem.exists(a) ? mem[a] : (~a ^ 64'h5a5a_0f0f_3c3c_9696);
  endfunction

  // Monitor: one MEM/WB update per clock edge while expectations are pending
  always @(posedge clk) begin
    exp_t e;
    logic [63:0] md;
    #1;
    if (q.size() > 0) begin
      e = q.pop_front();
      md = e.chk_md ? mem_data_out : 64'd0;
      check("mem_wb", {mem_to_reg_out, reg_write_en_out, alu_out_out, md, rd_out} === {e.m2r, e.rwe, e.alu, e.md, e.rd},
            $sformatf("got m2r=%b rwe=%b alu=%h md=%h rd=%0d want m2r=%b rwe=%b alu=%h md=%h rd=%0d",
                      mem_to_reg_out, reg_write_en_out, alu_out_out, md, rd_out, e.m2r, e.rwe, e.alu, e.md, e.rd));
      check("flags", {misaligned_err, bus_err, dmem_req} === {e.mis, e.berr, e.req},
            $sformatf("got mis=%b berr=%b req=%b want mis=%b berr=%b req=%b",
                      misaligned_err, bus_err, dmem_req, e.mis, e.berr, e.req));
    end
  end

  // Memory responder: acks in the ack_delay-th request cycle (0 = never), random acks while idle
  always @(posedge clk) begin
    #2;
    if (dmem_req) begin
      rcnt++;
      check("bus", {dmem_we, dmem_addr, dmem_we ? dmem_wdata : 64'd0} === {cur_we, cur_addr, cur_we ? cur_wdata : 64'd0},
            $sformatf("got we=%b addr=%h wdata=%h want we=%b addr=%h wdata=%h",
                      dmem_we, dmem_addr, dmem_wdata, cur_we, cur_addr, cur_wdata));
      dmem_ack = rcnt == ack_delay;
      dmem_rdata = (dmem_ack && !dmem_we) ? rmem(dmem_addr) : {$urandom(), $urandom()};
      if (dmem_ack && dmem_we) mem[dmem_addr] = dmem_wdata;
    end else begin
      rcnt = 0;
      dmem_ack = $urandom_range(0, 3) == 0;
      dmem_rdata = {$urandom(), $urandom()};
    end
  end

  task automatic issue(input bit mr, input bit mw, input bit m2r, input bit rwe,
                       input logic [63:0] a, input logic [63:0] wd, input logic [4:0] r, input int dly);
    exp_t e;
    int n;
    int sx;
    int st;
    mem_read = mr; mem_write = mw; mem_to_reg = m2r; reg_write_en = rwe;
    alu_out = a; data = wd; rd = r;
    branch = 1'($urandom()); z_flag = 1'($urandom()); pc_next = {$urandom(), $urandom()};
    cur_addr = a; cur_wdata = wd; cur_we = mw; ack_delay = dly;
    e = '0;
    st = 0;
    if (!(mr | mw)) begin
      e.m2r = m2r; e.rwe = rwe; e.alu = a; e.rd = r;
      q.push_back(e); n = 1; sx = 0;
    end else if (a[2:0] != 3'b000) begin
      e.mis = 1'b1; e.chk_md = 1'b1;
      q.push_back(e); n = 1; sx = 0;
    end else if (dly < 1 || dly > TO) begin
      e.chk_md = 1'b1; e.req = 1'b1;
      repeat (TO) q.push_back(e);
      e.req = 1'b0; e.berr = 1'b1;
      q.push_back(e); n = TO + 1; sx = TO;
    end else begin
      e.chk_md = 1'b1; e.req = 1'b1;
      repeat (dly) q.push_back(e);
      e.req = 1'b0; e.m2r = m2r; e.rwe = rwe; e.alu = a; e.rd = r; e.md = mw ? 64'd0 : rmem(a);
      q.push_back(e); n = dly + 1; sx = dly;
    end
    #1;
    check("branch", {pc_src, pc_target} === {branch & z_flag, pc_next},
          $sformatf("got src=%b tgt=%h want src=%b tgt=%h", pc_src, pc_target, branch & z_flag, pc_next));
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      st += int'(stall);
      @(posedge clk);
    end
    #3;
    check("stall_cycles", st == sx, $sformatf("got %0d want %0d", st, sx));
  endtask

  initial begin
    int kind, dly;
    logic [63:0] a;
    {mem_to_reg, reg_write_en, mem_read, mem_write, branch, z_flag} = '0;
    alu_out = '0; data = '0; rd = '0; pc_next = '0;
    mem[64'h100] = 64'hDEAD_BEEF;
    @(posedge clk);
    #3;
    check("reset_state", {dmem_req, dmem_we, dmem_addr, dmem_wdata, misaligned_err, bus_err, mem_to_reg_out,
                          reg_write_en_out, alu_out_out, mem_data_out, rd_out, stall} === '0, "outputs not all zero");
    reset_n = 1'b1;
    @(posedge clk);
    #3;
    issue(0, 0, 0, 1, 64'h1234, 64'h0, 5'd5, 1);
    issue(1, 0, 1, 1, 64'h100, 64'h0, 5'd7, 3);
    issue(0, 1, 0, 0, 64'h208, 64'hA5, 5'd0, 2);
    issue(1, 0, 1, 1, 64'h103, 64'h0, 5'd9, 1);
    issue(1, 0, 1, 1, 64'h208, 64'h0, 5'd3, 0);
    issue(1, 0, 1, 1, 64'h208, 64'h0, 5'd4, TO);
    issue(1, 1, 0, 0, 64'h300, 64'h1122_3344_5566_7788, 5'd6, 1);
    issue(1, 0, 1, 1, 64'h300, 64'h0, 5'd8, 2);
    issue(0, 1, 0, 0, 64'h308, 64'h77, 5'd0, 0);
    issue(1, 0, 1, 1, 64'h308, 64'h0, 5'd10, 1);
    mem_read = 1'b1; mem_write = 1'b0; alu_out = 64'h400; rd = 5'd11; reg_write_en = 1'b1; mem_to_reg = 1'b1;
    cur_addr = 64'h400; cur_we = 1'b0; ack_delay = 0;
    @(posedge clk);
    #4;
    check("req_before_reset", dmem_req === 1'b1, $sformatf("got %b want 1", dmem_req));
    reset_n = 1'b0;
    #1;
    check("async_reset", {dmem_req, dmem_we, dmem_addr, dmem_wdata, misaligned_err, bus_err, mem_to_reg_out,
                          reg_write_en_out, alu_out_out, mem_data_out, rd_out, stall} === '0,
          $sformatf("got req=%b addr=%h stall=%b", dmem_req, dmem_addr, stall));
    {mem_to_reg, reg_write_en, mem_read, mem_write} = '0;
    @(posedge clk);
    #3;
    reset_n = 1'b1;
    @(posedge clk);
    #3;
    check("after_reset", {dmem_req, stall} === 2'b00, $sformatf("got req=%b stall=%b want 0 0", dmem_req, stall));
    for (int i = 0; i < 80; i++) begin
      kind = $urandom_range(0, 9);
      dly = ($urandom_range(0, 7) == 0) ? 0 : $urandom_range(1, TO);
      a = 64'h1000 + 64'($urandom_range(0, 15)) * 8;
      if (kind < 3) issue(0, 0, 1'($urandom()), 1'($urandom()), {$urandom(), $urandom()}, 64'h0, 5'($urandom()), 1);
      else if (kind < 6) issue(1, 0, 1, 1, a, {$urandom(), $urandom()}, 5'($urandom()), dly);
      else if (kind < 8) issue(0, 1, 0, 0, a, {$urandom(), $urandom()}, 5'($urandom()), dly);
      else if (kind == 8) issue(1, 1, 0, 0, a, {$urandom(), $urandom()}, 5'($urandom()), dly);
      else issue(1, 1'($urandom()), 1, 1, 64'h1000 + 64'($urandom_range(1, 7)), 64'h0, 5'($urandom()), dly);
    end
    @(posedge clk);
    #3;
    check("queue_drained", q.size() == 0, $sformatf("got %0d pending want 0", q.size()));
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
